// File: rtl/upload_packer_pkg.sv
// upload_packer_pkg: shared types and constants for the upload packet framer.
//   state_e        - framer FSM states
//   DefaultHdr0/1  - default sync bytes that open every frame
//   FrameOverhead  - bytes on the wire beyond the payload (2 sync, source, 2 length, checksum)
package upload_packer_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StCollect,
      StHdr,
      StPayload,
      StCsum
   } state_e;

   localparam logic [7:0] DefaultHdr0 = 8'hAA;
   localparam logic [7:0] DefaultHdr1 = 8'h44;

   localparam int unsigned FrameOverhead = 6;

endpackage

// File: rtl/packer_buf_ram.sv
// packer_buf_ram: simple dual-port byte RAM with one write port and a registered read port,
// shaped so synthesis maps it onto block RAM.
//   clk    - clock
//   we     - write enable
//   waddr  - write address
//   wdata  - write data
//   raddr  - read address, sampled on the clock edge
//   rdata  - read data, valid one cycle after raddr
module packer_buf_ram #(
   parameter int unsigned Depth = 256,
   parameter int unsigned Aw    = $clog2(Depth)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [Aw-1:0] waddr,
   input  logic [7:0]    wdata,
   input  logic [Aw-1:0] raddr,
   output logic [7:0]    rdata
);

   logic [7:0] mem [Depth];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
      rdata <= mem[raddr];
   end

endmodule

// File: rtl/upload_packer.sv
// upload_packer: buffers one upload burst from a peripheral handler and re-emits it as a framed
// byte packet: HDR0, HDR1, source, len_hi, len_lo, payload..., checksum. The checksum is the
// 8-bit sum of source, payload and both length bytes.
//   clk, rst_n      - clock, synchronous active-low reset
//   upload_active   - handler burst in progress
//   upload_req      - handler requests the channel (informational only)
//   upload_data     - payload byte, qualified by upload_valid
//   upload_source   - source/command ID of the byte
//   upload_valid    - upload_data valid
//   upload_ready    - packer accepts the byte this cycle
//   out_data        - framed byte stream, qualified by out_valid
//   out_valid       - out_data valid
//   out_ready       - downstream accepts out_data
//   busy            - packer is not idle
module upload_packer
   import upload_packer_pkg::*;
#(
   parameter int unsigned MAX_PAYLOAD = 256,
   parameter logic [7:0]  HDR0        = DefaultHdr0,
   parameter logic [7:0]  HDR1        = DefaultHdr1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       upload_active,
   input  logic       upload_req,
   input  logic [7:0] upload_data,
   input  logic [7:0] upload_source,
   input  logic       upload_valid,
   output logic       upload_ready,
   output logic [7:0] out_data,
   output logic       out_valid,
   input  logic       out_ready,
   output logic       busy
);

   localparam int unsigned Aw = $clog2(MAX_PAYLOAD);
   localparam int unsigned Cw = Aw + 1;
   // Header index that follows len_lo; reaching it hands over to the payload.
   localparam logic [2:0] HdrLast = 3'(FrameOverhead - 1);

   state_e          state_q, state_d;
   logic [Cw-1:0]   count_q, count_d;
   logic [Cw-1:0]   rd_ptr_q, rd_ptr_d;
   logic [7:0]      src_q, src_d;
   logic [7:0]      csum_q, csum_d;
   logic [2:0]      idx_q, idx_d;
   logic [7:0]      out_data_q, out_data_d;
   logic            out_valid_q, out_valid_d;

   logic [7:0]      rd_data;
   logic [7:0]      hdr_byte;
   logic [15:0]     len;
   logic            src_mismatch;
   logic            accept;
   logic            handshake;

   // Intake is governed by upload_valid alone; the request line carries no extra meaning here.
   logic unused_req;
   assign unused_req = upload_req;

   assign len          = 16'(count_q);
   assign src_mismatch = (state_q == StCollect) && upload_valid && (upload_source != src_q);
   assign upload_ready = rst_n && ((state_q == StIdle) || (state_q == StCollect)) &&
                         (count_q < Cw'(MAX_PAYLOAD)) && !src_mismatch;
   assign accept       = upload_valid && upload_ready;
   assign handshake    = out_valid_q && out_ready;

   assign out_data  = out_data_q;
   assign out_valid = out_valid_q;
   assign busy      = (state_q != StIdle);

   always_comb begin
      hdr_byte = HDR0;
      case (idx_q)
         3'd1:    hdr_byte = HDR1;
         3'd2:    hdr_byte = src_q;
         3'd3:    hdr_byte = len[15:8];
         3'd4:    hdr_byte = len[7:0];
         default: hdr_byte = HDR0;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      count_d     = count_q;
      rd_ptr_d    = rd_ptr_q;
      src_d       = src_q;
      csum_d      = csum_q;
      idx_d       = idx_q;
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;

      unique case (state_q)
         StIdle: begin
            rd_ptr_d = '0;
            if (accept) begin
               src_d   = upload_source;
               csum_d  = upload_source + upload_data;
               count_d = Cw'(1);
               state_d = StCollect;
            end
         end

         StCollect: begin
            if (accept) begin
               csum_d  = csum_q + upload_data;
               count_d = count_q + Cw'(1);
            end else if (!upload_active || (count_q == Cw'(MAX_PAYLOAD)) || src_mismatch) begin
               // Close: fold the length into the checksum and present HDR0 right away.
               csum_d      = csum_q + len[15:8] + len[7:0];
               state_d     = StHdr;
               out_valid_d = 1'b1;
               out_data_d  = HDR0;
               idx_d       = 3'd1;
            end
         end

         StHdr: begin
            if (handshake) begin
               if (idx_q == HdrLast) begin
                  // rd_data already holds buf[0]; start prefetching buf[1].
                  out_data_d = rd_data;
                  rd_ptr_d   = Cw'(1);
                  state_d    = StPayload;
               end else begin
                  out_data_d = hdr_byte;
                  idx_d      = idx_q + 3'd1;
               end
            end
         end

         StPayload: begin
            // rd_ptr_q indexes the byte currently waiting in rd_data.
            if (handshake) begin
               if (rd_ptr_q == count_q) begin
                  out_data_d = csum_q;
                  state_d    = StCsum;
               end else begin
                  out_data_d = rd_data;
                  rd_ptr_d   = rd_ptr_q + Cw'(1);
               end
            end
         end

         StCsum: begin
            if (handshake) begin
               out_valid_d = 1'b0;
               state_d     = StIdle;
               count_d     = '0;
               rd_ptr_d    = '0;
               idx_d       = '0;
            end
         end

         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         count_q     <= '0;
         rd_ptr_q    <= '0;
         src_q       <= '0;
         csum_q      <= '0;
         idx_q       <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         rd_ptr_q    <= rd_ptr_d;
         src_q       <= src_d;
         csum_q      <= csum_d;
         idx_q       <= idx_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
      end
   end

   // Read address follows the next-state pointer so the RAM latency is hidden behind the
   // output register and bytes stream without bubbles.
   packer_buf_ram #(
      .Depth (MAX_PAYLOAD),
      .Aw    (Aw)
   ) u_buf (
      .clk   (clk),
      .we    (accept),
      .waddr (count_q[Aw-1:0]),
      .wdata (upload_data),
      .raddr (rd_ptr_d[Aw-1:0]),
      .rdata (rd_data)
   );

endmodule

// File: tb/tb_upload_packer.sv
// tb_upload_packer: directed tests for upload_packer built with a 4-byte payload buffer.
module tb_upload_packer;

   localparam int unsigned MaxPayload = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       upload_active = 1'b0;
   logic       upload_req = 1'b0;
   logic [7:0] upload_data = 8'h00;
   logic [7:0] upload_source = 8'h00;
   logic       upload_valid = 1'b0;
   logic       upload_ready;
   logic [7:0] out_data;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic       busy;

   int total = 0;
   int passed = 0;
   logic [7:0] cap[$];

   always #5 clk = ~clk;

   upload_packer #(
      .MAX_PAYLOAD (MaxPayload)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .upload_active (upload_active),
      .upload_req    (upload_req),
      .upload_data   (upload_data),
      .upload_source (upload_source),
      .upload_valid  (upload_valid),
      .upload_ready  (upload_ready),
      .out_data      (out_data),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .busy          (busy)
   );

   // Record every byte that completes an output handshake at the coming edge.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) cap.push_back(out_data);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] src, input logic [7:0] data, input int budget,
                            output bit ok);
      logic r;
      upload_active = 1'b1;
      upload_req    = 1'b1;
      upload_valid  = 1'b1;
      upload_source = src;
      upload_data   = data;
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         r = upload_ready;
         step();
         if (r) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic end_burst();
      upload_valid  = 1'b0;
      upload_active = 1'b0;
      upload_req    = 1'b0;
   endtask

   task automatic wait_cap(input int n, input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         if (cap.size() >= n) begin
            ok = 1'b1;
            break;
         end
         step();
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      step();
      step();
      total++;
      if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", out_valid);
      else passed++;
      total++;
      if (out_data !== 8'h00) $display("FAIL reset_out_data: got %02h expected 00", out_data);
      else passed++;
      total++;
      if (upload_ready !== 1'b0) $display("FAIL reset_ready: got %b expected 0", upload_ready);
      else passed++;
      total++;
      if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy);
      else passed++;
      rst_n = 1'b1;
      @(negedge clk);
      total++;
      if (upload_ready !== 1'b1) $display("FAIL idle_ready: got %b expected 1", upload_ready);
      else passed++;
      step();
   endtask

   task automatic test_basic();
      bit ok;
      logic [7:0] exp[$];
      cap.delete();
      out_ready = 1'b1;
      send_byte(8'h03, 8'hA5, 20, ok);
      total++;
      if (!ok) $display("FAIL basic_send0: accepted=0 expected 1"); else passed++;
      send_byte(8'h03, 8'hA5, 20, ok);
      total++;
      if (!ok) $display("FAIL basic_send1: accepted=0 expected 1"); else passed++;
      end_burst();
      wait_cap(8, 60, ok);
      total++;
      if (!ok) $display("FAIL basic_timeout: got %0d bytes expected 8", cap.size()); else passed++;
      exp = '{8'hAA, 8'h44, 8'h03, 8'h00, 8'h02, 8'hA5, 8'hA5, 8'h4F};
      total++;
      if (cap.size() != exp.size())
         $display("FAIL basic_len: got %0d expected %0d", cap.size(), exp.size());
      else passed++;
      for (int i = 0; i < exp.size(); i++) begin
         total++;
         if (i >= cap.size()) $display("FAIL basic_byte[%0d]: got none expected %02h", i, exp[i]);
         else if (cap[i] !== exp[i])
            $display("FAIL basic_byte[%0d]: got %02h expected %02h", i, cap[i], exp[i]);
         else passed++;
      end
      total++;
      if (busy !== 1'b0) $display("FAIL basic_busy: got %b expected 0", busy); else passed++;
      step();
   endtask

   task automatic test_backpressure();
      bit ok;
      bit hold;
      logic [7:0] held;
      logic [7:0] exp[$];
      cap.delete();
      out_ready = 1'b0;
      send_byte(8'h03, 8'hA5, 20, ok);
      send_byte(8'h03, 8'hA5, 20, ok);
      total++;
      if (!ok) $display("FAIL bp_send: accepted=0 expected 1"); else passed++;
      end_burst();
      hold = 1'b0;
      held = 8'h00;
      for (int c = 0; c < 40; c++) begin
         out_ready = (c % 2 == 0);
         @(negedge clk);
         if (hold) begin
            total++;
            if (out_valid !== 1'b1 || out_data !== held)
               $display("FAIL bp_hold: got valid=%b data=%02h expected valid=1 data=%02h",
                        out_valid, out_data, held);
            else passed++;
         end
         hold = out_valid && !out_ready;
         held = out_data;
         step();
      end
      out_ready = 1'b1;
      wait_cap(8, 40, ok);
      exp = '{8'hAA, 8'h44, 8'h03, 8'h00, 8'h02, 8'hA5, 8'hA5, 8'h4F};
      total++;
      if (cap.size() != exp.size())
         $display("FAIL bp_len: got %0d expected %0d", cap.size(), exp.size());
      else passed++;
      for (int i = 0; i < exp.size(); i++) begin
         total++;
         if (i >= cap.size()) $display("FAIL bp_byte[%0d]: got none expected %02h", i, exp[i]);
         else if (cap[i] !== exp[i])
            $display("FAIL bp_byte[%0d]: got %02h expected %02h", i, cap[i], exp[i]);
         else passed++;
      end
      step();
   endtask

   task automatic test_max_payload();
      bit ok;
      logic r;
      logic [7:0] exp[$];
      cap.delete();
      out_ready = 1'b1;
      for (int b = 1; b <= 4; b++) begin
         send_byte(8'h01, 8'(b), 20, ok);
         total++;
         if (!ok) $display("FAIL max_send%0d: accepted=0 expected 1", b); else passed++;
      end
      // Offer byte 05 while the full buffer drains; it must wait for the next packet.
      upload_source = 8'h01;
      upload_data   = 8'h05;
      upload_valid  = 1'b1;
      r = 1'b0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (!busy) begin
            r = upload_ready;
            break;
         end
         total++;
         if (upload_ready !== 1'b0)
            $display("FAIL max_ready_busy: got %b expected 0", upload_ready);
         else passed++;
         step();
      end
      total++;
      if (r !== 1'b1) $display("FAIL max_ready_idle: got %b expected 1", r); else passed++;
      step();
      send_byte(8'h01, 8'h06, 20, ok);
      total++;
      if (!ok) $display("FAIL max_send6: accepted=0 expected 1"); else passed++;
      end_burst();
      wait_cap(18, 60, ok);
      exp = '{8'hAA, 8'h44, 8'h01, 8'h00, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0F,
              8'hAA, 8'h44, 8'h01, 8'h00, 8'h02, 8'h05, 8'h06, 8'h0E};
      total++;
      if (cap.size() != exp.size())
         $display("FAIL max_len: got %0d expected %0d", cap.size(), exp.size());
      else passed++;
      for (int i = 0; i < exp.size(); i++) begin
         total++;
         if (i >= cap.size()) $display("FAIL max_byte[%0d]: got none expected %02h", i, exp[i]);
         else if (cap[i] !== exp[i])
            $display("FAIL max_byte[%0d]: got %02h expected %02h", i, cap[i], exp[i]);
         else passed++;
      end
      step();
   endtask

   task automatic test_source_switch();
      bit ok;
      logic [7:0] exp[$];
      cap.delete();
      out_ready = 1'b1;
      send_byte(8'h01, 8'h11, 20, ok);
      total++;
      if (!ok) $display("FAIL src_send0: accepted=0 expected 1"); else passed++;
      send_byte(8'h02, 8'h22, 50, ok);
      total++;
      if (!ok) $display("FAIL src_send1: accepted=0 expected 1"); else passed++;
      end_burst();
      wait_cap(14, 60, ok);
      exp = '{8'hAA, 8'h44, 8'h01, 8'h00, 8'h01, 8'h11, 8'h13,
              8'hAA, 8'h44, 8'h02, 8'h00, 8'h01, 8'h22, 8'h25};
      total++;
      if (cap.size() != exp.size())
         $display("FAIL src_len: got %0d expected %0d", cap.size(), exp.size());
      else passed++;
      for (int i = 0; i < exp.size(); i++) begin
         total++;
         if (i >= cap.size()) $display("FAIL src_byte[%0d]: got none expected %02h", i, exp[i]);
         else if (cap[i] !== exp[i])
            $display("FAIL src_byte[%0d]: got %02h expected %02h", i, cap[i], exp[i]);
         else passed++;
      end
      step();
   endtask

   task automatic test_idle_pulse();
      cap.delete();
      out_ready = 1'b1;
      upload_active = 1'b1;
      upload_valid  = 1'b0;
      for (int c = 0; c < 12; c++) begin
         if (c == 10) upload_active = 1'b0;
         @(negedge clk);
         total++;
         if (out_valid !== 1'b0 || busy !== 1'b0)
            $display("FAIL idle_pulse[%0d]: got valid=%b busy=%b expected valid=0 busy=0",
                     c, out_valid, busy);
         else passed++;
         step();
      end
      total++;
      if (cap.size() != 0) $display("FAIL idle_pulse_out: got %0d bytes expected 0", cap.size());
      else passed++;
   endtask

   task automatic test_reset_mid_frame();
      bit ok;
      logic [7:0] exp[$];
      cap.delete();
      out_ready = 1'b1;
      send_byte(8'h03, 8'hA5, 20, ok);
      send_byte(8'h03, 8'hA5, 20, ok);
      end_burst();
      wait_cap(6, 60, ok);
      total++;
      if (!ok) $display("FAIL rstmid_reach: got %0d bytes expected 6", cap.size()); else passed++;
      rst_n = 1'b0;
      step();
      total++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || out_data !== 8'h00)
         $display("FAIL rstmid_state: got valid=%b busy=%b data=%02h expected 0 0 00",
                  out_valid, busy, out_data);
      else passed++;
      rst_n = 1'b1;
      step();
      cap.delete();
      send_byte(8'h05, 8'h10, 20, ok);
      total++;
      if (!ok) $display("FAIL rstmid_send: accepted=0 expected 1"); else passed++;
      end_burst();
      wait_cap(7, 60, ok);
      exp = '{8'hAA, 8'h44, 8'h05, 8'h00, 8'h01, 8'h10, 8'h16};
      total++;
      if (cap.size() != exp.size())
         $display("FAIL rstmid_len: got %0d expected %0d", cap.size(), exp.size());
      else passed++;
      for (int i = 0; i < exp.size(); i++) begin
         total++;
         if (i >= cap.size()) $display("FAIL rstmid_byte[%0d]: got none expected %02h", i, exp[i]);
         else if (cap[i] !== exp[i])
            $display("FAIL rstmid_byte[%0d]: got %02h expected %02h", i, cap[i], exp[i]);
         else passed++;
      end
      step();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_max_payload();
      test_source_switch();
      test_idle_pulse();
      test_reset_mid_frame();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
